reg_bank_wr_demux: RTL and testbench

//  Write-side counterpart of the 32-way word read mux. Decodes a 5-bit write

---
 rtl/reg_bank_wr_demux.sv | 194 +++++++++++++++++++
 tb/tb_reg_bank_wr_demux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wr_demux.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_wr_demux
//  Purpose  : Write side of a 32-entry register bank. A 5-bit write address
//             is decoded to one-hot and the data word is written into the
//             addressed register. A sequenced bulk-clear engine can zero the
//             bank one word per cycle and reports BUSY while it runs.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1      rising-edge clock
//    rst      in   1      synchronous active-high reset
//    WE       in   1      write request
//    WA       in   5      write address
//    WD       in   WIDTH  write data
//    CLR      in   1      bulk-clear request
//    BUSY     out  1      high while the clear sequence runs
//    WR_ACK   out  1      pulse: previous cycle's write was accepted
//    DEC      out  32     registered one-hot of the accepted address, else 0
//    Q0..Q31  out  WIDTH  register contents
// ============================================================================
module reg_bank_wr_demux #(
    parameter int WIDTH   = 32,
    parameter int ZERO_R0 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WE,
    input  logic [4:0]       WA,
    input  logic [WIDTH-1:0] WD,
    input  logic             CLR,
    output logic             BUSY,
    output logic             WR_ACK,
    output logic [31:0]      DEC,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7,
    output logic [WIDTH-1:0] Q8,
    output logic [WIDTH-1:0] Q9,
    output logic [WIDTH-1:0] Q10,
    output logic [WIDTH-1:0] Q11,
    output logic [WIDTH-1:0] Q12,
    output logic [WIDTH-1:0] Q13,
    output logic [WIDTH-1:0] Q14,
    output logic [WIDTH-1:0] Q15,
    output logic [WIDTH-1:0] Q16,
    output logic [WIDTH-1:0] Q17,
    output logic [WIDTH-1:0] Q18,
    output logic [WIDTH-1:0] Q19,
    output logic [WIDTH-1:0] Q20,
    output logic [WIDTH-1:0] Q21,
    output logic [WIDTH-1:0] Q22,
    output logic [WIDTH-1:0] Q23,
    output logic [WIDTH-1:0] Q24,
    output logic [WIDTH-1:0] Q25,
    output logic [WIDTH-1:0] Q26,
    output logic [WIDTH-1:0] Q27,
    output logic [WIDTH-1:0] Q28,
    output logic [WIDTH-1:0] Q29,
    output logic [WIDTH-1:0] Q30,
    output logic [WIDTH-1:0] Q31
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_clear = 1'b1;
    localparam logic [4:0] c_last_idx = 5'd31;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [4:0]       r_cnt;
    logic [4:0]       w_cnt_nxt;
    logic             r_wr_ack;
    logic [31:0]      r_dec;
    logic [WIDTH-1:0] r_q [32];

    logic             w_wr_accept;
    logic             w_wr_discard;

    // A write is only taken in IDLE and loses to a simultaneous clear request.
    assign w_wr_accept  = (r_state == c_st_idle) && WE && !CLR;
    // Register 0 may be hardwired to zero: the write is acknowledged but the
    // data is thrown away.
    assign w_wr_discard = (ZERO_R0 != 0) && (WA == 5'd0);

    // ------------------------------------------------------------------------
    // Clear sequencer: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Clear sequencer: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == c_st_idle) begin
            if (CLR) begin
                w_state_nxt = c_st_clear;
                w_cnt_nxt   = 5'd0;
            end
        end else begin
            // CLR is ignored here so the sequence can never restart or stretch.
            // The counter wraps to 0 after the last register.
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_cnt == c_last_idx) begin
                w_state_nxt = c_st_idle;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write acknowledge and one-hot decode
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ack <= 1'b0;
            r_dec    <= 32'd0;
        end else begin
            r_wr_ack <= w_wr_accept;
            r_dec    <= w_wr_accept ? (32'd1 << WA) : 32'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Register storage. Writes and clears never coincide because writes are
    // only accepted in IDLE and clearing only happens in CLEAR.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            if (w_wr_accept && !w_wr_discard) begin
                r_q[WA] <= WD;
            end
            if (r_state == c_st_clear) begin
                r_q[r_cnt] <= '0;
            end
        end
    end

    assign BUSY   = (r_state == c_st_clear);
    assign WR_ACK = r_wr_ack;
    assign DEC    = r_dec;

    assign Q0  = (ZERO_R0 != 0) ? '0 : r_q[0];
    assign Q1  = r_q[1];
    assign Q2  = r_q[2];
    assign Q3  = r_q[3];
    assign Q4  = r_q[4];
    assign Q5  = r_q[5];
    assign Q6  = r_q[6];
    assign Q7  = r_q[7];
    assign Q8  = r_q[8];
    assign Q9  = r_q[9];
    assign Q10 = r_q[10];
    assign Q11 = r_q[11];
    assign Q12 = r_q[12];
    assign Q13 = r_q[13];
    assign Q14 = r_q[14];
    assign Q15 = r_q[15];
    assign Q16 = r_q[16];
    assign Q17 = r_q[17];
    assign Q18 = r_q[18];
    assign Q19 = r_q[19];
    assign Q20 = r_q[20];
    assign Q21 = r_q[21];
    assign Q22 = r_q[22];
    assign Q23 = r_q[23];
    assign Q24 = r_q[24];
    assign Q25 = r_q[25];
    assign Q26 = r_q[26];
    assign Q27 = r_q[27];
    assign Q28 = r_q[28];
    assign Q29 = r_q[29];
    assign Q30 = r_q[30];
    assign Q31 = r_q[31];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_wr_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_bank_wr_demux
//  Purpose  : Self-checking bench for reg_bank_wr_demux. Directed scenarios
//             followed by random traffic, compared every cycle against a
//             behavioural model of the register bank.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_bank_wr_demux;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             WE;
    logic [4:0]       WA;
    logic [WIDTH-1:0] WD;
    logic             CLR;
    logic             BUSY;
    logic             WR_ACK;
    logic [31:0]      DEC;
    logic [WIDTH-1:0] q [32];

    int tests;
    int fails;

    // Behavioural model
    logic [WIDTH-1:0] m_q [32];
    bit               m_busy;
    int               m_idx;
    bit               m_ack;
    logic [31:0]      m_dec;

    reg_bank_wr_demux #(.WIDTH(WIDTH), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .WE(WE), .WA(WA), .WD(WD), .CLR(CLR),
        .BUSY(BUSY), .WR_ACK(WR_ACK), .DEC(DEC),
        .Q0(q[0]),   .Q1(q[1]),   .Q2(q[2]),   .Q3(q[3]),
        .Q4(q[4]),   .Q5(q[5]),   .Q6(q[6]),   .Q7(q[7]),
        .Q8(q[8]),   .Q9(q[9]),   .Q10(q[10]), .Q11(q[11]),
        .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
        .Q16(q[16]), .Q17(q[17]), .Q18(q[18]), .Q19(q[19]),
        .Q20(q[20]), .Q21(q[21]), .Q22(q[22]), .Q23(q[23]),
        .Q24(q[24]), .Q25(q[25]), .Q26(q[26]), .Q27(q[27]),
        .Q28(q[28]), .Q29(q[29]), .Q30(q[30]), .Q31(q[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies the rules of the bank to the inputs present at this edge.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_q[i] = '0;
            m_busy = 0; m_idx = 0; m_ack = 0; m_dec = '0;
        end else if (m_busy) begin
            m_q[m_idx] = '0;
            m_idx      = m_idx + 1;
            if (m_idx == 32) m_busy = 0;
            m_ack = 0; m_dec = '0;
        end else if (CLR) begin
            m_busy = 1; m_idx = 0; m_ack = 0; m_dec = '0;
        end else if (WE) begin
            m_ack = 1;
            m_dec = '0;
            m_dec[WA] = 1'b1;
            if (WA != 5'd0) m_q[WA] = WD;
        end else begin
            m_ack = 0; m_dec = '0;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":busy"}, {31'd0, BUSY}, {31'd0, m_busy});
        chk({ph, ":ack"},  {31'd0, WR_ACK}, {31'd0, m_ack});
        chk({ph, ":dec"},  DEC, m_dec);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s:q%0d", ph, i), q[i], m_q[i]);
        end
    endtask

    // One clock edge with the currently driven inputs, then a full check.
    task automatic cyc(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    initial begin
        int n;
        tests = 0; fails = 0;
        for (int i = 0; i < 32; i++) m_q[i] = 'x;
        m_busy = 0; m_idx = 0; m_ack = 0; m_dec = '0;
        rst = 1'b1; WE = 1'b0; WA = 5'd0; WD = '0; CLR = 1'b0;

        // 1. reset
        @(posedge clk); model_edge(); #1;
        cyc("reset");
        rst = 1'b0;
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_ack", {31'd0, WR_ACK}, 32'd0);
        chk("reset_dec", DEC, 32'd0);
        chk("reset_q17", q[17], 32'd0);

        // 2. basic write
        WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF;
        cyc("wr5");
        WE = 1'b0;
        chk("wr5_q5", q[5], 32'hDEADBEEF);
        chk("wr5_ack", {31'd0, WR_ACK}, 32'd1);
        chk("wr5_dec", DEC, 32'h00000020);
        cyc("wr5_after");
        chk("wr5_ack_drop", {31'd0, WR_ACK}, 32'd0);
        chk("wr5_dec_drop", DEC, 32'd0);

        // 3. write to hardwired register 0
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF;
        cyc("wr0");
        WE = 1'b0;
        chk("wr0_q0", q[0], 32'd0);
        chk("wr0_ack", {31'd0, WR_ACK}, 32'd1);
        chk("wr0_dec", DEC, 32'h1);

        // 4. fill bank then bulk clear
        for (int k = 1; k < 32; k++) begin
            WE = 1'b1; WA = 5'(k); WD = 32'(k + 1);
            cyc("fill");
        end
        WE = 1'b0;
        chk("fill_q31", q[31], 32'd32);
        CLR = 1'b1;
        cyc("clr_start");
        CLR = 1'b0;
        n = 0;
        while (BUSY && n < 40) begin
            n++;
            cyc("clearing");
        end
        chk("clr_busy_len", 32'(n), 32'd32);
        chk("clr_q20_zero", q[20], 32'd0);

        // 5. clear wins over simultaneous write; held write acked after clear
        WE = 1'b1; WA = 5'd3; WD = 32'h55;
        cyc("pre3");
        CLR = 1'b1; WE = 1'b1; WA = 5'd3; WD = 32'd7;
        cyc("clr_we");
        CLR = 1'b0;
        chk("clr_we_q3", q[3], 32'h55);
        chk("clr_we_ack", {31'd0, WR_ACK}, 32'd0);
        chk("clr_we_busy", {31'd0, BUSY}, 32'd1);
        n = 0;
        while (BUSY && n < 40) begin
            n++;
            cyc("held_we");
        end
        chk("held_busy_len", 32'(n), 32'd32);
        chk("held_ack_at_idle", {31'd0, WR_ACK}, 32'd0);
        cyc("held_ack");
        chk("held_ack_first", {31'd0, WR_ACK}, 32'd1);
        chk("held_q3", q[3], 32'd7);
        WE = 1'b0;

        // 6. reset in the middle of a clear
        for (int k = 20; k < 24; k++) begin
            WE = 1'b1; WA = 5'(k); WD = 32'hA000 + 32'(k);
            cyc("pre_rst");
        end
        WE = 1'b0;
        CLR = 1'b1;
        cyc("rclr_start");
        CLR = 1'b0;
        for (int k = 0; k < 10; k++) cyc("rclr");
        rst = 1'b1;
        cyc("mid_rst");
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("mid_rst_q22", q[22], 32'd0);
        WE = 1'b1; WA = 5'd31; WD = 32'h1234;
        cyc("wr31");
        WE = 1'b0;
        chk("wr31_q31", q[31], 32'h1234);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            WE  = 1'($urandom_range(0, 1));
            WA  = 5'($urandom_range(0, 31));
            WD  = $urandom;
            CLR = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc("rand");
        end
        rst = 1'b0; WE = 1'b0; CLR = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
